// File: rtl/i2c_cfg_sequencer_if.sv
// I2C pin bundle between the config sequencer and its open-drain pads.
interface i2c_cfg_sequencer_if;
    logic scl_o;   // 1 = release SCL, 0 = drive low
    logic sda_oe;  // 1 = drive SDA low, 0 = release
    logic sda_i;   // synchronised SDA pad level

    modport master (
        output scl_o,
        output sda_oe,
        input  sda_i
    );

    modport slave (
        input  scl_o,
        input  sda_oe,
        output sda_i
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// I2C master that writes a table of 16-bit register words to one slave,
// with per-word NACK retry, re-run on start, and status outputs.
module i2c_cfg_sequencer #(
    parameter int unsigned NUM_WORDS  = 11,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned CLK_DIV    = 125,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset_n,
    input  logic                               start,
    input  logic [16*NUM_WORDS-1:0]            cfg_table,
    i2c_cfg_sequencer_if.master                i2c,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [$clog2(NUM_WORDS+1)-1:0]     word_idx,
    output logic [7:0]                         nack_cnt
);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BYTE  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       nack_cnt_q, nack_cnt_d;
    logic             nack_flag_q, nack_flag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             auto_q, auto_d;

    logic [15:0]      word_c;
    logic [7:0]       tx_byte_c;
    logic             qtick_c;
    logic             idle_c;
    logic             launch_c;

    assign qtick_c  = (div_q == DIV_W'(CLK_DIV - 1));
    assign idle_c   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign launch_c = idle_c && (start || auto_q);

    // Select the table word addressed by word_idx.
    always_comb begin
        word_c = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_idx_q == IDX_W'(k)) word_c = cfg_table[16*k +: 16];
        end
    end

    // Next-state, counters, status and pin levels (pins derived from the next phase).
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        div_d       = '0;
        word_idx_d  = word_idx_q;
        retry_d     = retry_q;
        nack_cnt_d  = nack_cnt_q;
        nack_flag_d = nack_flag_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        auto_d      = 1'b0;
        tx_byte_c   = '0;
        scl_d       = 1'b1;
        sda_oe_d    = 1'b0;

        if (idle_c) begin
            if (launch_c) begin
                state_d     = S_START;
                qtr_d       = 2'd0;
                word_idx_d  = '0;
                retry_d     = '0;
                nack_cnt_d  = '0;
                nack_flag_d = 1'b0;
                done_d      = 1'b0;
                error_d     = 1'b0;
                busy_d      = 1'b1;
            end
        end else begin
            div_d = qtick_c ? '0 : div_q + DIV_W'(1);
            if (qtick_c) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d     = S_BYTE;
                            byte_d      = 2'd0;
                            bit_d       = 3'd7;
                            nack_flag_d = 1'b0;
                        end
                        S_BYTE: begin
                            if (bit_q == 3'd0) state_d = S_ACK;
                            else               bit_d   = bit_q - 3'd1;
                        end
                        S_ACK: begin
                            if (i2c.sda_i) begin
                                if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
                                nack_flag_d = 1'b1;
                                state_d     = S_STOP;
                            end else if (byte_q == 2'd2) begin
                                state_d = S_STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                state_d = S_BYTE;
                            end
                        end
                        S_STOP: begin
                            if (!nack_flag_q) begin
                                word_idx_d = word_idx_q + IDX_W'(1);
                                retry_d    = '0;
                                if (word_idx_q == IDX_W'(NUM_WORDS - 1)) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                end else begin
                                    state_d = S_START;
                                end
                            end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                                retry_d = retry_q + RTY_W'(1);
                                state_d = S_START;
                            end else begin
                                state_d = S_ERR;
                                error_d = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        case (byte_d)
            2'd0:    tx_byte_c = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte_c = word_c[15:8];
            default: tx_byte_c = word_c[7:0];
        endcase

        case (state_d)
            S_START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = qtr_d[1];
            end
            S_BYTE: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~tx_byte_c[bit_d];
            end
            S_ACK: begin
                scl_d    = qtr_d[1];
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases both bus lines immediately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            bit_q       <= 3'd7;
            byte_q      <= 2'd0;
            div_q       <= '0;
            word_idx_q  <= '0;
            retry_q     <= '0;
            nack_cnt_q  <= '0;
            nack_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            auto_q      <= AUTO_START;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            div_q       <= div_d;
            word_idx_q  <= word_idx_d;
            retry_q     <= retry_d;
            nack_cnt_q  <= nack_cnt_d;
            nack_flag_q <= nack_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
            auto_q      <= auto_d;
        end
    end

    assign i2c.scl_o  = scl_q;
    assign i2c.sda_oe = sda_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_idx   = word_idx_q;
    assign nack_cnt   = nack_cnt_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench: I2C slave model on instance A (auto start), always-ACK bus on instance B (manual start).
module tb_i2c_cfg_sequencer;
    localparam int unsigned NW        = 2;
    localparam int unsigned CD        = 4;
    localparam int unsigned BUSY_MIN  = NW * 116 * CD;
    localparam int unsigned BUSY_MAX  = NW * 122 * CD + 8;
    localparam int unsigned RUN_LIMIT = 4000;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start_a = 1'b0;
    logic              start_b = 1'b0;
    logic [16*NW-1:0]  cfg     = {16'h0C00, 16'h1E00};
    logic              busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0]        idx_a, idx_b;
    logic [7:0]        nack_a, nack_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_ok  [6] = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h00};
    logic [7:0] exp_rty [8] = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h34, 8'h0C, 8'h00};

    i2c_cfg_sequencer_if bus_a ();
    i2c_cfg_sequencer_if bus_b ();

    logic slv_drive = 1'b0;
    wire  scl_line  = bus_a.scl_o;
    wire  sda_line  = ~bus_a.sda_oe & ~slv_drive;
    assign bus_a.sda_i = sda_line;
    assign bus_b.sda_i = 1'b0;

    always #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .NUM_WORDS(NW), .DEV_ADDR(7'h1A), .CLK_DIV(CD), .MAX_RETRY(3), .AUTO_START(1'b1)
    ) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start_a), .cfg_table(cfg), .i2c(bus_a),
        .busy(busy_a), .done(done_a), .error(err_a), .word_idx(idx_a), .nack_cnt(nack_a)
    );

    i2c_cfg_sequencer #(
        .NUM_WORDS(NW), .DEV_ADDR(7'h1A), .CLK_DIV(CD), .MAX_RETRY(3), .AUTO_START(1'b0)
    ) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start_b), .cfg_table(cfg), .i2c(bus_b),
        .busy(busy_b), .done(done_b), .error(err_b), .word_idx(idx_b), .nack_cnt(nack_b)
    );

    // Slave model: mode 0 ACKs all, 1 NACKs byte 1 of the second frame once, 2 NACKs every address byte.
    int         nack_mode = 0;
    int         clr_gen   = 0;
    int         clr_seen  = 0;
    logic [7:0] rx_q [$];
    int         starts    = 0;
    int         byte_idx  = 0;
    int         bit_cnt   = 0;
    logic       in_frame  = 1'b0;
    logic       ack_phase = 1'b0;
    logic       nacked_once = 1'b0;
    logic       scl_p     = 1'b1;
    logic       sda_p     = 1'b1;
    logic [7:0] shreg     = '0;
    wire        nack_now  = (nack_mode == 2 && byte_idx == 0) ||
                            (nack_mode == 1 && starts == 2 && byte_idx == 1 && !nacked_once);

    // Bus snapshot per clock; START/STOP/bit edges detected from consecutive snapshots.
    always @(negedge clk) begin
        scl_p <= scl_line;
        sda_p <= sda_line;
        if (clr_seen != clr_gen) begin
            clr_seen    <= clr_gen;
            rx_q.delete();
            starts      <= 0;
            byte_idx    <= 0;
            bit_cnt     <= 0;
            nacked_once <= 1'b0;
            in_frame    <= 1'b0;
            ack_phase   <= 1'b0;
            slv_drive   <= 1'b0;
        end else if (scl_p && scl_line && sda_p && !sda_line) begin
            starts    <= starts + 1;
            in_frame  <= 1'b1;
            bit_cnt   <= 0;
            byte_idx  <= 0;
            ack_phase <= 1'b0;
            slv_drive <= 1'b0;
        end else if (scl_p && scl_line && !sda_p && sda_line) begin
            in_frame  <= 1'b0;
            ack_phase <= 1'b0;
            slv_drive <= 1'b0;
        end else if (in_frame && !scl_p && scl_line) begin
            if (bit_cnt < 8) begin
                shreg   <= {shreg[6:0], sda_line};
                bit_cnt <= bit_cnt + 1;
                if (bit_cnt == 7) rx_q.push_back({shreg[6:0], sda_line});
            end
        end else if (in_frame && scl_p && !scl_line) begin
            if (bit_cnt == 8 && !ack_phase) begin
                ack_phase <= 1'b1;
                slv_drive <= ~nack_now;
                if (nack_mode == 1 && nack_now) nacked_once <= 1'b1;
            end else if (ack_phase) begin
                ack_phase <= 1'b0;
                slv_drive <= 1'b0;
                bit_cnt   <= 0;
                byte_idx  <= byte_idx + 1;
            end
        end
    end

    task clear_slave(input int mode);
        nack_mode = mode;
        clr_gen   = clr_gen + 1;
        repeat (2) @(negedge clk);
    endtask

    task pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_a.scl_o !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", bus_a.scl_o); end
        n_checks++; if (bus_a.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", bus_a.sda_oe); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", err_a); end
        n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL reset_word_idx: got %0d want 0", idx_a); end
        n_checks++; if (nack_a !== 8'd0) begin n_fail++; $display("FAIL reset_nack_cnt: got %0d want 0", nack_a); end
    endtask

    task test_ack_all();
        int cnt;
        logic [7:0] got;
        clear_slave(0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (busy_a) cnt++;
            if (done_a || err_a) break;
        end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL ack_all_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ack_all_error: got %b want 0", err_a); end
        n_checks++; if (idx_a !== 2'd2) begin n_fail++; $display("FAIL ack_all_word_idx: got %0d want 2", idx_a); end
        n_checks++; if (nack_a !== 8'd0) begin n_fail++; $display("FAIL ack_all_nack_cnt: got %0d want 0", nack_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ack_all_busy_end: got %b want 0", busy_a); end
        n_checks++; if (cnt < BUSY_MIN || cnt > BUSY_MAX) begin n_fail++; $display("FAIL ack_all_busy_cycles: got %0d want %0d..%0d", cnt, BUSY_MIN, BUSY_MAX); end
        n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL ack_all_byte_count: got %0d want 6", rx_q.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            n_checks++; if (got !== exp_ok[k]) begin n_fail++; $display("FAIL ack_all_byte%0d: got %h want %h", k, got, exp_ok[k]); end
        end
        n_checks++; if (bus_a.scl_o !== 1'b1 || bus_a.sda_oe !== 1'b0) begin n_fail++; $display("FAIL ack_all_lines: got scl=%b oe=%b want scl=1 oe=0", bus_a.scl_o, bus_a.sda_oe); end
    endtask

    task test_idle_no_start();
        repeat (20) @(negedge clk);
        n_checks++; if (bus_b.scl_o !== 1'b1 || bus_b.sda_oe !== 1'b0) begin n_fail++; $display("FAIL idle_lines: got scl=%b oe=%b want scl=1 oe=0", bus_b.scl_o, bus_b.sda_oe); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_b); end
        n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b want 0", done_b); end
    endtask

    task test_manual_start();
        int cnt;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL manual_busy_rise: got %b want 1", busy_b); end
        cnt = busy_b ? 1 : 0;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (i == 100) start_b = 1'b1;
            if (i == 101) start_b = 1'b0;
            if (busy_b) cnt++;
            if (done_b || err_b) break;
        end
        n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL manual_done: got %b want 1", done_b); end
        n_checks++; if (idx_b !== 2'd2) begin n_fail++; $display("FAIL manual_word_idx: got %0d want 2", idx_b); end
        n_checks++; if (cnt < BUSY_MIN || cnt > BUSY_MAX) begin n_fail++; $display("FAIL manual_no_restart_busy_cycles: got %0d want %0d..%0d", cnt, BUSY_MIN, BUSY_MAX); end
    endtask

    task test_restart_after_done();
        logic [7:0] got;
        clear_slave(0);
        pulse_start_a();
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL restart_done_cleared: got %b want 0", done_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy_a); end
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (done_a || err_a) break;
        end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", done_a); end
        n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL restart_byte_count: got %0d want 6", rx_q.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            n_checks++; if (got !== exp_ok[k]) begin n_fail++; $display("FAIL restart_byte%0d: got %h want %h", k, got, exp_ok[k]); end
        end
    endtask

    task test_nack_retry();
        logic [7:0] got;
        clear_slave(1);
        pulse_start_a();
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (done_a || err_a) break;
        end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL retry_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL retry_error: got %b want 0", err_a); end
        n_checks++; if (nack_a !== 8'd1) begin n_fail++; $display("FAIL retry_nack_cnt: got %0d want 1", nack_a); end
        n_checks++; if (idx_a !== 2'd2) begin n_fail++; $display("FAIL retry_word_idx: got %0d want 2", idx_a); end
        n_checks++; if (rx_q.size() != 8) begin n_fail++; $display("FAIL retry_byte_count: got %0d want 8", rx_q.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            n_checks++; if (got !== exp_rty[k]) begin n_fail++; $display("FAIL retry_byte%0d: got %h want %h", k, got, exp_rty[k]); end
        end
    endtask

    task test_retry_exhaust();
        logic [7:0] got;
        clear_slave(2);
        pulse_start_a();
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (done_a || err_a) break;
        end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL exhaust_error: got %b want 1", err_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL exhaust_done: got %b want 0", done_a); end
        n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL exhaust_word_idx: got %0d want 0", idx_a); end
        n_checks++; if (nack_a !== 8'd4) begin n_fail++; $display("FAIL exhaust_nack_cnt: got %0d want 4", nack_a); end
        n_checks++; if (starts != 4) begin n_fail++; $display("FAIL exhaust_attempts: got %0d want 4", starts); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL exhaust_busy: got %b want 0", busy_a); end
        repeat (10) @(negedge clk);
        n_checks++; if (bus_a.scl_o !== 1'b1 || bus_a.sda_oe !== 1'b0) begin n_fail++; $display("FAIL exhaust_lines: got scl=%b oe=%b want scl=1 oe=0", bus_a.scl_o, bus_a.sda_oe); end
        for (int k = 0; k < 4; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            n_checks++; if (got !== 8'h34) begin n_fail++; $display("FAIL exhaust_byte%0d: got %h want 34", k, got); end
        end
    endtask

    task test_reset_mid();
        logic [7:0] got;
        clear_slave(0);
        pulse_start_a();
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL mid_error_cleared: got %b want 0", err_a); end
        n_checks++; if (nack_a !== 8'd0) begin n_fail++; $display("FAIL mid_nack_cleared: got %0d want 0", nack_a); end
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (rx_q.size() >= 4) break;
        end
        repeat (40) @(negedge clk);
        n_checks++; if (idx_a !== 2'd1) begin n_fail++; $display("FAIL mid_word_idx_before: got %0d want 1", idx_a); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus_a.scl_o !== 1'b1 || bus_a.sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_async_lines: got scl=%b oe=%b want scl=1 oe=0", bus_a.scl_o, bus_a.sda_oe); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b want 0", busy_a); end
        n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL mid_async_word_idx: got %0d want 0", idx_a); end
        clear_slave(0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (done_a || err_a) break;
        end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_done: got %b want 1", done_a); end
        n_checks++; if (starts != 2) begin n_fail++; $display("FAIL mid_rerun_starts: got %0d want 2", starts); end
        n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL mid_rerun_byte_count: got %0d want 6", rx_q.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            n_checks++; if (got !== exp_ok[k]) begin n_fail++; $display("FAIL mid_rerun_byte%0d: got %h want %h", k, got, exp_ok[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_ack_all();
        test_idle_no_start();
        test_manual_start();
        test_restart_after_done();
        test_nack_retry();
        test_retry_exhaust();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
